fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
Shares one combinational 32-bit floating-point adder between N_REQ requesters, such as neuron-update lanes accumulating synaptic weights into membrane potentials. A round-robin arbiter picks one requester per cycle and registers its operands onto the adder inputs. The adder output is captured in a result register and returned with the requester ID over a valid/ready handshake. The block is a two-stage pipeline with full backpressure; the adder itself is instantiated outside this block.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, 2, width of requester ID; must equal ceil(log2(N_REQ)), minimum 1
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester operation request
req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle
req_a  input  32*N_REQ  operand A, requester i at bits [32i+31:32i]
req_b  input  32*N_REQ  operand B, same packing
add_a  output  32  operand A to the shared adder (registered)
add_b  output  32  operand B to the shared adder (registered)
add_result  input  32  combinational adder output for add_a + add_b
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  32  sum
res_id  output  ID_W  requester that issued the operation
busy  output  1  s1_valid OR res_valid
op_count  output  CNT_W  results delivered since reset; saturates at all-ones

Behaviour:
- Reset (asynchronous, rst_n low): s1_valid=0, res_valid=0, add_a=0, add_b=0, res_data=0, res_id=0, op_count=0, rr_ptr=0, req_ready=0, busy=0.
  - Reset asserted mid-operation discards all in-flight work. No result is emitted.
- Stage S1 registers: s1_valid, add_a, add_b, s1_id.
- Stage S2 registers: res_valid, res_data, res_id.
- Advance conditions (combinational):
  - s2_load = s1_valid AND (NOT res_valid OR res_ready)
  - s1_free = NOT s1_valid OR s2_load
- Arbitration:
  - When s1_free, grant the first requester with req_valid high, searching from rr_ptr upward with wrap-around.
  - req_ready[g]=1 only for the granted g. All req_ready bits are 0 when NOT s1_free or no request is pending.
  - req_ready depends on req_valid combinationally. The requester must not make req_valid depend on req_ready.
- Transfer: occurs when req_valid[g] AND req_ready[g].
  - S1 loads add_a=req_a[g], add_b=req_b[g], s1_id=g, s1_valid=1.
  - rr_ptr becomes (g+1) mod N_REQ.
  - rr_ptr is unchanged when no transfer occurs.
- S2 load: on s2_load, res_data<=add_result, res_id<=s1_id, res_valid<=1.
  - If s2_load occurs with no new transfer, s1_valid<=0.
- Output: if res_valid AND res_ready AND NOT s2_load, then res_valid<=0.
  - Simultaneous pop and load keeps res_valid=1 with the new data.
- Latency: transfer in cycle T gives res_valid=1 in cycle T+2. Unstalled throughput is one operation per cycle.
- Hold rule: while res_valid=1 and res_ready=0, res_data and res_id are held stable. S1 holds, and req_ready is 0 for all requesters once S1 is full.
- op_count increments by 1 on each res_valid AND res_ready. It holds at 2^CNT_W-1 and never wraps.
- Fairness: a requester holding req_valid is granted within N_REQ grants.
- Operand values are passed through unmodified; no checks for NaN or denormal operands are made here.
- Requester indices at or above N_REQ do not exist; ID decode covers only 0..N_REQ-1.

Test Plan:
1. Single op: after reset, req_valid=0001, req_a[0]=0x3F800000 (1.0), req_b[0]=0x3F800000, res_ready=1.
   -> req_ready[0]=1 in cycle T; res_valid=1 in cycle T+2 with res_data=0x40000000, res_id=0; op_count=1.
2. Round robin: all four req_valid held high, res_ready=1 for 8 cycles.
   -> grants in order 0,1,2,3,0,1,2,3; res_id follows the same order two cycles later; one req_ready bit per cycle.
3. Backpressure: two ops (requester 1: 0x3FC00000+0x40200000, i.e. 1.5+2.5; requester 2: 1.0+1.0), res_ready=0 for 5 cycles, then 1.
   -> res_valid=1, res_data=0x40800000, res_id=1 held stable; req_ready=0 after S1 fills.
   -> after release, 0x40800000 then 0x40000000 (res_id=2) on consecutive cycles.
4. Pointer wrap: only requester 3 requests, then only requester 0.
   -> rr_ptr goes 3->0; requester 0 is granted on its first request cycle.
5. Reset mid-flight: rst_n low for 1 cycle while S1 and S2 are valid.
   -> res_valid, req_ready, busy and op_count drop to 0 immediately (asynchronously); no stale result after reset release.
6. Counter saturation with CNT_W=3: deliver 9 results.
   -> op_count reads 7 after the 7th result and stays 7.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - requester and result handshake bundle for the shared fp adder
interface fp_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_data;
  logic [ID_W-1:0]     res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one fp adder with a two-stage backpressured pipe
module fp_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_add_arbiter_if.slave  bus,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ-1);

  logic            s1_valid;
  logic [ID_W-1:0] s1_id;
  logic [ID_W-1:0] rr_ptr;
  logic            s2_load;
  logic            s1_free;
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic            transfer;
  logic [31:0]     lane_a [N_REQ];
  logic [31:0]     lane_b [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_a[i] = bus.req_a[32*i +: 32];
    assign lane_b[i] = bus.req_b[32*i +: 32];
  end

  assign s2_load  = s1_valid & (~bus.res_valid | bus.res_ready);
  assign s1_free  = ~s1_valid | s2_load;
  assign transfer = s1_free & grant_found;
  assign busy     = s1_valid | bus.res_valid;

  // Round-robin search: first pending requester at or after rr_ptr, wrapping below N_REQ
  always_comb begin
    logic [ID_W:0] cand;
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  // One-hot accept for the granted requester; held low while reset is asserted
  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_ready[i] = rst_n & transfer & (grant_id == ID_W'(i));
    end
  end

  // Stage S1: capture granted operands onto the adder inputs and advance the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      add_a    <= '0;
      add_b    <= '0;
      rr_ptr   <= '0;
    end else if (transfer) begin
      s1_valid <= 1'b1;
      s1_id    <= grant_id;
      add_a    <= lane_a[grant_id];
      add_b    <= lane_b[grant_id];
      rr_ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage S2: capture the adder sum; a simultaneous pop and load keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
    end else if (s2_load) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= add_result;
      bus.res_id    <= s1_id;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

  // Delivered-result counter, sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (bus.res_valid && bus.res_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - randomized and directed check of fp_add_arbiter against a queue-free stage model
module tb_fp_add_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic [31:0] add_a, add_b, add_result;
  logic [31:0] add_a2, add_b2, add_result2;
  logic busy, busy2;
  logic [15:0] op_count;
  logic [2:0]  op_count_sat;

  int n_cmp = 0;
  int n_fail = 0;

  fp_add_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();
  fp_add_arbiter_if #(.N_REQ(N), .ID_W(2)) bus2 ();

  fp_add_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .busy(busy), .op_count(op_count)
  );

  fp_add_arbiter #(.N_REQ(N), .ID_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .add_a(add_a2), .add_b(add_b2),
    .add_result(add_result2), .busy(busy2), .op_count(op_count_sat)
  );

  assign bus2.req_valid = bus.req_valid;
  assign bus2.req_a     = bus.req_a;
  assign bus2.req_b     = bus.req_b;
  assign bus2.res_ready = bus.res_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // float32 <-> real through the double encoding (normal operands only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [22:0] m;
    e = 8'($urandom_range(120, 134));
    m = 23'($urandom);
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  // External combinational adders
  always_comb add_result  = fadd(add_a, add_b);
  always_comb add_result2 = fadd(add_a2, add_b2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_s1_v, m_s2_v;
  logic [31:0] m_s1_a, m_s1_b, m_s2_data;
  int          m_s1_id, m_s2_id;
  int          m_ptr;
  int          m_cnt;
  logic [N-1:0] acc_mask;
  int          waits [N];

  function automatic void find_grant(input logic [N-1:0] v, input int ptr,
                                     output bit found, output int g);
    found = 0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (!found && v[idx]) begin
        found = 1;
        g = idx;
      end
    end
  endfunction

  // Advance the model one clock using the inputs that are stable at the edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1_v = 0; m_s2_v = 0; m_s1_a = 0; m_s1_b = 0; m_s2_data = 0;
      m_s1_id = 0; m_s2_id = 0; m_ptr = 0; m_cnt = 0; acc_mask = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      bit found, free, pop, move;
      int g;
      find_grant(bus.req_valid, m_ptr, found, g);
      free = !m_s1_v || !m_s2_v || bus.res_ready;
      acc_mask = (free && found) ? N'(1 << g) : '0;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          chk($sformatf("fair_wait%0d", i), 64'(waits[i] < N), 64'd1);
          waits[i] = 0;
        end else if (!bus.req_valid[i]) begin
          waits[i] = 0;
        end else if (acc_mask != '0) begin
          waits[i]++;
        end
      end
      pop  = m_s2_v && bus.res_ready;
      move = m_s1_v && (!m_s2_v || bus.res_ready);
      if (pop) m_cnt++;
      if (move) begin
        m_s2_v = 1; m_s2_data = fadd(m_s1_a, m_s1_b); m_s2_id = m_s1_id;
      end else if (pop) begin
        m_s2_v = 0;
      end
      if (acc_mask != '0) begin
        m_s1_v = 1; m_s1_a = bus.req_a[32*g +: 32]; m_s1_b = bus.req_b[32*g +: 32];
        m_s1_id = g; m_ptr = (g + 1) % N;
      end else if (move) begin
        m_s1_v = 0;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge
  always @(negedge clk) begin
    bit found;
    int g;
    logic [N-1:0] exp_rr;
    find_grant(bus.req_valid, m_ptr, found, g);
    exp_rr = (rst_n && found && (!m_s1_v || !m_s2_v || bus.res_ready)) ? N'(1 << g) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
    chk("res_valid", 64'(bus.res_valid), 64'(m_s2_v));
    chk("busy", 64'(busy), 64'(m_s1_v || m_s2_v));
    chk("op_count", 64'(op_count), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("op_count_sat", 64'(op_count_sat), 64'((m_cnt > 7) ? 7 : m_cnt));
    if (m_s2_v) begin
      chk("res_data", 64'(bus.res_data), 64'(m_s2_data));
      chk("res_id", 64'(bus.res_id), 64'(m_s2_id));
    end
    if (m_s1_v) begin
      chk("add_a", 64'(add_a), 64'(m_s1_a));
      chk("add_b", 64'(add_b), 64'(m_s1_b));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  initial begin
    logic [N-1:0] e_rr;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b0;

    chk("pin_fadd_1p1", 64'(fadd(32'h3F800000, 32'h3F800000)), 64'h40000000);
    chk("pin_fadd_1p5_2p5", 64'(fadd(32'h3FC00000, 32'h40200000)), 64'h40800000);

    // Reset state and single operation
    do_reset();
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    set_op(0, 32'h3F800000, 32'h3F800000);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b1;
    #1 chk("t1_req_ready", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = '0;
    tick();
    chk("t1_res_valid", 64'(bus.res_valid), 64'd1);
    chk("t1_res_data", 64'(bus.res_data), 64'h40000000);
    chk("t1_res_id", 64'(bus.res_id), 64'd0);
    tick();
    chk("t1_op_count", 64'(op_count), 64'd1);
    chk("t1_res_drop", 64'(bus.res_valid), 64'd0);

    // Round robin with every requester pending
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, rnd_fp(), rnd_fp());
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus.req_valid = '0;
      #1;
      e_rr = N'(1 << (c % 4));
      if (c < 8) chk("t2_grant", 64'(bus.req_ready), 64'(e_rr));
      if (c >= 2) begin
        chk("t2_res_valid", 64'(bus.res_valid), 64'd1);
        chk("t2_res_id", 64'(bus.res_id), 64'((c - 2) % 4));
      end
      tick();
    end

    // Backpressure holds result and S1
    do_reset();
    bus.res_ready = 1'b0;
    set_op(1, 32'h3FC00000, 32'h40200000);
    set_op(2, 32'h3F800000, 32'h3F800000);
    bus.req_valid = 4'b0110;
    #1 chk("t3_grant1", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.req_valid = 4'b0100;
    #1 chk("t3_grant2", 64'(bus.req_ready), 64'b0100);
    tick();
    bus.req_valid = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("t3_hold_valid", 64'(bus.res_valid), 64'd1);
      chk("t3_hold_data", 64'(bus.res_data), 64'h40800000);
      chk("t3_hold_id", 64'(bus.res_id), 64'd1);
      chk("t3_hold_ready", 64'(bus.req_ready), 64'd0);
      tick();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    #1;
    chk("t3_out1_data", 64'(bus.res_data), 64'h40800000);
    chk("t3_out1_id", 64'(bus.res_id), 64'd1);
    tick();
    chk("t3_out2_valid", 64'(bus.res_valid), 64'd1);
    chk("t3_out2_data", 64'(bus.res_data), 64'h40000000);
    chk("t3_out2_id", 64'(bus.res_id), 64'd2);
    tick();
    chk("t3_empty", 64'(bus.res_valid), 64'd0);
    chk("t3_op_count", 64'(op_count), 64'd2);

    // Pointer wrap 3 -> 0
    do_reset();
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1 chk("t4_grant3", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = 4'b0001;
    #1 chk("t4_grant0", 64'(bus.req_ready), 64'b0001);
    tick();
    bus.req_valid = 4'b1001;
    #1 chk("t4_grant3_again", 64'(bus.req_ready), 64'b1000);
    tick();
    bus.req_valid = '0;
    tick();
    tick();

    // Asynchronous reset with both stages full
    do_reset();
    bus.res_ready = 1'b1;
    set_op(0, rnd_fp(), rnd_fp());
    set_op(1, rnd_fp(), rnd_fp());
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0011;
    tick();
    tick();
    bus.req_valid = 4'b1111;
    #1;
    chk("t5_pre_busy", 64'(busy), 64'd1);
    chk("t5_pre_res_valid", 64'(bus.res_valid), 64'd1);
    chk("t5_pre_op_count", 64'(op_count), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_res_valid", 64'(bus.res_valid), 64'd0);
    chk("t5_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_op_count", 64'(op_count), 64'd0);
    tick();
    rst_n = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t5_no_stale", 64'(bus.res_valid), 64'd0);
      tick();
    end

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, rnd_fp(), rnd_fp());
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 9; c++) tick();
    bus.req_valid = '0;
    tick();
    tick();
    tick();
    chk("t6_op_count_full", 64'(op_count), 64'd9);
    chk("t6_op_count_sat", 64'(op_count_sat), 64'd7);

    // Randomized traffic with holding requesters and random backpressure
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 99) < 40) begin
          set_op(i, rnd_fp(), rnd_fp());
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.res_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("drain_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
